dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arb_if.sv | 33 +++
 rtl/dmem_arb_timeout.sv | 21 ++
 rtl/dmem_arb.sv | 114 +++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: data width, FSM states,
// owner encoding and the latched access record.
package dmem_arb_pkg;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;
endpackage

// File: rtl/dmem_arb_if.sv
// Signal bundle between the MEM stage, the debug/loader port and the single
// data-memory port. slave = arbiter view, master = environment view.
interface dmem_arb_if;
    import dmem_arb_pkg::*;

    logic              mem_req, mem_we, mem_done, stall;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;

    logic              dbg_req, dbg_we, dbg_done;
    logic [STRB_W-1:0] dbg_wstrb;
    logic [DATA_W-1:0] dbg_addr, dbg_wdata, dbg_rdata;

    logic              bus_valid, bus_we, bus_ready, bus_err;
    logic [STRB_W-1:0] bus_wstrb;
    logic [DATA_W-1:0] bus_addr, bus_wdata, bus_rdata;

    modport slave (
        input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
        input  dbg_req, dbg_we, dbg_wstrb, dbg_addr, dbg_wdata,
        input  bus_ready, bus_rdata,
        output mem_rdata, mem_done, stall, dbg_rdata, dbg_done,
        output bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
        output dbg_req, dbg_we, dbg_wstrb, dbg_addr, dbg_wdata,
        output bus_ready, bus_rdata,
        input  mem_rdata, mem_done, stall, dbg_rdata, dbg_done,
        input  bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/dmem_arb_timeout.sv
// Bus-wait watchdog: counts enabled cycles and flags the LIMIT-th one.
module dmem_arb_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)  r_cnt <= '0;
        else if (count_en) r_cnt <= r_cnt + 1'b1;
    end

    assign expired = count_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/dmem_arb.sv
// Two-requester (MEM stage / debug port) arbiter onto one data-memory port.
// Define DMEM_ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    dmem_arb_if.slave  bif
);
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t            r_state, w_next;
    owner_t            r_owner;
    acc_t              r_acc, w_mem_acc, w_dbg_acc;
    logic [SW-1:0]     r_starve;
    logic [DATA_W-1:0] r_mem_rdata, r_dbg_rdata;
    logic              w_any_req, w_grant_dbg, w_hs, w_timeout;

    always_comb begin
        w_mem_acc   = '{we: bif.mem_we, wstrb: bif.mem_wstrb, addr: bif.mem_addr, wdata: bif.mem_wdata};
        w_dbg_acc   = '{we: bif.dbg_we, wstrb: bif.dbg_wstrb, addr: bif.dbg_addr, wdata: bif.dbg_wdata};
        w_any_req   = bif.mem_req || bif.dbg_req;
        // MEM has priority until DBG has been passed over STARVE_LIMIT times
        w_grant_dbg = bif.dbg_req && (!bif.mem_req || r_starve == STARVE_MAX);
        w_hs        = (r_state == ACCESS) && bif.bus_ready;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ACCESS;
            ACCESS:  if (w_hs || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_owner     <= OWN_MEM;
            r_acc       <= '0;
            r_starve    <= '0;
            r_mem_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_dbg ? OWN_DBG : OWN_MEM;
                        r_acc   <= w_grant_dbg ? w_dbg_acc : w_mem_acc;
                    end
                    if (!bif.dbg_req || w_grant_dbg) r_starve <= '0;
                    else if (r_starve != STARVE_MAX) r_starve <= r_starve + 1'b1;
                end
                ACCESS: begin
                    if (w_hs && !r_acc.we) begin
                        if (r_owner == OWN_DBG) r_dbg_rdata <= bif.bus_rdata;
                        else                    r_mem_rdata <= bif.bus_rdata;
                    end else if (w_timeout) begin
                        if (r_owner == OWN_DBG) r_dbg_rdata <= '0;
                        else                    r_mem_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    dmem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .count_en ((r_state == ACCESS) && !bif.bus_ready),
        .clear    (r_state != ACCESS),
        .expired  (w_expired)
    );

    // Registered so the error pulse lines up with the DONE cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_err <= 1'b0;
        else         r_err <= w_expired;
    end

    assign w_timeout   = w_expired;
    assign bif.bus_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bif.bus_err = 1'b0;
`endif

    assign bif.bus_valid = (r_state == ACCESS);
    assign bif.bus_we    = bif.bus_valid ? r_acc.we    : 1'b0;
    assign bif.bus_wstrb = bif.bus_valid ? r_acc.wstrb : '0;
    assign bif.bus_addr  = bif.bus_valid ? r_acc.addr  : '0;
    assign bif.bus_wdata = bif.bus_valid ? r_acc.wdata : '0;

    assign bif.mem_done  = (r_state == DONE) && (r_owner == OWN_MEM);
    assign bif.dbg_done  = (r_state == DONE) && (r_owner == OWN_DBG);
    assign bif.mem_rdata = r_mem_rdata;
    assign bif.dbg_rdata = r_dbg_rdata;
    assign bif.stall     = bif.mem_req && !bif.mem_done;
endmodule
